// File: rtl/bitwise_operand_loader_if.sv
// Operand-staging bus between the nibble source / AND-array side and
// bitwise_operand_loader. nibble_par only exists when PARITY_CHECK_EN is defined.
interface bitwise_operand_loader_if #(
   parameter int WIDTH = 16
);
   localparam int BEATS = WIDTH / 4;
   localparam int CW    = $clog2(2 * BEATS) + 1;

   logic [3:0]       nibble_in;
   logic             nibble_valid;
`ifdef PARITY_CHECK_EN
   logic             nibble_par;
`endif
   logic             in_ready;
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic             op_valid;
   logic             op_ready;
   logic [CW-1:0]    load_count;
   logic             parity_err;

   // Source / consumer side
   modport master (
`ifdef PARITY_CHECK_EN
      output nibble_par,
`endif
      output nibble_in, nibble_valid, op_ready,
      input  in_ready, a_out, b_out, op_valid, load_count, parity_err
   );

   // Loader side
   modport slave (
`ifdef PARITY_CHECK_EN
      input  nibble_par,
`endif
      input  nibble_in, nibble_valid, op_ready,
      output in_ready, a_out, b_out, op_valid, load_count, parity_err
   );
endinterface

// File: rtl/bitwise_operand_loader.sv
// bitwise_operand_loader: assembles operand A then operand B from a stream of
// LSB-first nibbles and presents both as a stable pair to the AND array.
// Optional feature macro: PARITY_CHECK_EN (even-parity check on each nibble).
module bitwise_operand_loader #(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   bitwise_operand_loader_if.slave bus
);
   localparam int BEATS = WIDTH / 4;
   localparam int CW    = $clog2(2 * BEATS) + 1;
   localparam logic [CW-1:0] LAST_A = CW'(BEATS - 1);
   localparam logic [CW-1:0] LAST_B = CW'(2 * BEATS - 1);

   typedef enum logic [1:0] {LOAD_A, LOAD_B, PRESENT} state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_next;
   logic [WIDTH-1:0] a_hold;
   logic [CW-1:0]    count;
   logic             handshake;
   logic             bad_par;

   assign bus.in_ready   = (state != PRESENT);
   assign bus.load_count = count;
   assign handshake      = bus.nibble_valid && bus.in_ready;
   assign sr_next        = {bus.nibble_in, sr[WIDTH-1:4]};

`ifdef PARITY_CHECK_EN
   assign bad_par = ^{bus.nibble_in, bus.nibble_par};
`else
   assign bad_par = 1'b0;
`endif

   // Shift every offered nibble in; dropped ones are harmless because each
   // operand takes exactly BEATS shifts after the count restarts at 0.
   always_ff @(posedge clk) begin
      if (handshake)
         sr <= sr_next;
   end

   // Load/present state machine with registered outputs and abort priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= LOAD_A;
         count          <= '0;
         a_hold         <= '0;
         bus.a_out      <= '0;
         bus.b_out      <= '0;
         bus.op_valid   <= 1'b0;
         bus.parity_err <= 1'b0;
      end else begin
         bus.parity_err <= 1'b0;
         if (clear) begin
            state        <= LOAD_A;
            count        <= '0;
            bus.op_valid <= 1'b0;
         end else if (handshake && bad_par) begin
            state          <= LOAD_A;
            count          <= '0;
            bus.op_valid   <= 1'b0;
            bus.parity_err <= 1'b1;
         end else begin
            case (state)
               LOAD_A: begin
                  if (handshake) begin
                     count <= count + 1'b1;
                     if (count == LAST_A) begin
                        a_hold <= sr_next;
                        state  <= LOAD_B;
                     end
                  end
               end
               LOAD_B: begin
                  if (handshake) begin
                     count <= count + 1'b1;
                     if (count == LAST_B) begin
                        bus.a_out    <= a_hold;
                        bus.b_out    <= sr_next;
                        bus.op_valid <= 1'b1;
                        state        <= PRESENT;
                     end
                  end
               end
               PRESENT: begin
                  if (bus.op_valid && bus.op_ready) begin
                     bus.op_valid <= 1'b0;
                     count        <= '0;
                     state        <= LOAD_A;
                  end
               end
               default: state <= LOAD_A;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_bitwise_operand_loader.sv
// Scoreboard bench for bitwise_operand_loader: a queue-based reference model
// predicts each operand pair; a negedge monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_bitwise_operand_loader;
   localparam int WIDTH = 16;
   localparam int BEATS = WIDTH / 4;

   logic clk = 1'b0;
   logic reset;
   logic clear;

   always #5 clk = ~clk;

   bitwise_operand_loader_if #(.WIDTH(WIDTH)) bus();

   bitwise_operand_loader #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [3:0]         nibs[$];
   logic [2*WIDTH-1:0] sb_q[$];
   bit                 presenting = 1'b0;
   bit                 exp_perr   = 1'b0;
   logic [WIDTH-1:0]   exp_a      = '0;
   logic [WIDTH-1:0]   exp_b      = '0;
   bit                 acc_evt    = 1'b0;
   bit                 chk_en     = 1'b0;
   bit                 prev_vld   = 1'b0;
   bit                 m_bad;
   logic [WIDTH-1:0]   m_a;
   logic [WIDTH-1:0]   m_b;
   logic [2*WIDTH-1:0] popped;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model: collects accepted nibbles; a full set of 2*BEATS forms a pair.
   always @(posedge clk) begin
`ifdef PARITY_CHECK_EN
      m_bad = ^{bus.nibble_in, bus.nibble_par};
`else
      m_bad = 1'b0;
`endif
      acc_evt = 1'b0;
      if (reset) begin
         nibs.delete();
         presenting = 1'b0;
         exp_perr   = 1'b0;
         exp_a      = '0;
         exp_b      = '0;
      end else if (clear) begin
         nibs.delete();
         presenting = 1'b0;
         exp_perr   = 1'b0;
      end else if (presenting) begin
         exp_perr = 1'b0;
         if (bus.op_ready) begin
            presenting = 1'b0;
            nibs.delete();
         end
      end else if (bus.nibble_valid) begin
         acc_evt = 1'b1;
         if (m_bad) begin
            nibs.delete();
            exp_perr = 1'b1;
         end else begin
            exp_perr = 1'b0;
            nibs.push_back(bus.nibble_in);
            if (nibs.size() == 2 * BEATS) begin
               m_a = '0;
               m_b = '0;
               for (int i = 0; i < BEATS; i++) begin
                  m_a = m_a | (WIDTH'(nibs[i]) << (4 * i));
                  m_b = m_b | (WIDTH'(nibs[BEATS + i]) << (4 * i));
               end
               sb_q.push_back({m_a, m_b});
               exp_a      = m_a;
               exp_b      = m_b;
               presenting = 1'b1;
            end
         end
      end else begin
         exp_perr = 1'b0;
      end
   end

   // Monitor: per-cycle output checks plus a scoreboard pop on each new pair.
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready",   64'(bus.in_ready),   64'(!presenting));
         check("op_valid",   64'(bus.op_valid),   64'(presenting));
         check("load_count", 64'(bus.load_count), 64'(nibs.size()));
         check("parity_err", 64'(bus.parity_err), 64'(exp_perr));
         check("a_out",      64'(bus.a_out),      64'(exp_a));
         check("b_out",      64'(bus.b_out),      64'(exp_b));
         if (bus.op_valid && !prev_vld) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_pair: got pair %0h/%0h, expected none", bus.a_out, bus.b_out);
            end else begin
               popped = sb_q.pop_front();
               check("sb_pair", 64'({bus.a_out, bus.b_out}), 64'(popped));
            end
         end
         prev_vld = bus.op_valid;
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(bit nv, logic [3:0] n, bit opr, bit clr, bit rst);
      bus.nibble_valid = nv;
      bus.nibble_in    = n;
      bus.op_ready     = opr;
      clear            = clr;
      reset            = rst;
`ifdef PARITY_CHECK_EN
      bus.nibble_par   = ^n;
`endif
   endtask

   task automatic send(logic [3:0] n, bit opr);
      int k;
      k = 0;
      drive(1'b1, n, opr, 1'b0, 1'b0);
      do begin
         step();
         k++;
      end while (!acc_evt && k < 50);
      if (!acc_evt) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", k);
      end
      drive(1'b0, n, opr, 1'b0, 1'b0);
   endtask

   task automatic send_pair(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, bit opr);
      for (int i = 0; i < BEATS; i++) send(a[4*i +: 4], opr);
      for (int i = 0; i < BEATS; i++) send(b[4*i +: 4], opr);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held for two edges
      drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
      step();
      chk_en = 1'b1;
      step();
      drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      step();

      // Basic load: A = F0F0, B = 3C3C
      send(4'h0, 1'b1); send(4'hF, 1'b1); send(4'h0, 1'b1); send(4'hF, 1'b1);
      send(4'hC, 1'b1); send(4'h3, 1'b1); send(4'hC, 1'b1); send(4'h3, 1'b1);
      check("basic_a",   64'(bus.a_out), 64'h0000_F0F0);
      check("basic_b",   64'(bus.b_out), 64'h0000_3C3C);
      check("basic_and", 64'(bus.a_out & bus.b_out), 64'h0000_3030);
      step();
      check("basic_one_cycle", 64'(bus.op_valid), 64'h0);

      // Backpressure: pair held while op_ready is low
      send_pair(16'h1234, 16'hFFFF, 1'b0);
      repeat (5) step();
      check("bp_valid", 64'(bus.op_valid), 64'h1);
      check("bp_a",     64'(bus.a_out),    64'h0000_1234);
      check("bp_b",     64'(bus.b_out),    64'h0000_FFFF);
      bus.op_ready = 1'b1;
      step();
      check("bp_release", 64'(bus.in_ready), 64'h1);

      // Clear after 3 nibbles, with a nibble offered on the clear cycle
      send(4'h5, 1'b1); send(4'h6, 1'b1); send(4'h7, 1'b1);
      drive(1'b1, 4'h9, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      check("clear_count", 64'(bus.load_count), 64'h0);
      check("clear_keep_a", 64'(bus.a_out), 64'h0000_1234);
      send_pair(16'hA5C3, 16'h0F96, 1'b1);
      step();

      // Reset in LOAD_B at count 6
      for (int i = 0; i < 6; i++) send(4'(i + 1), 1'b1);
      drive(1'b1, 4'hE, 1'b1, 1'b0, 1'b1);
      step();
      drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      check("rst_mid_a", 64'(bus.a_out), 64'h0);
      check("rst_mid_count", 64'(bus.load_count), 64'h0);
      send_pair(16'hBEEF, 16'h4D2B, 1'b1);
      step();

`ifdef PARITY_CHECK_EN
      // Bad parity on the 2nd nibble
      send(4'h1, 1'b1);
      drive(1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
      bus.nibble_par = ~bus.nibble_par;
      step();
      drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      check("par_pulse", 64'(bus.parity_err), 64'h1);
      check("par_count", 64'(bus.load_count), 64'h0);
      step();
      check("par_pulse_end", 64'(bus.parity_err), 64'h0);
      send_pair(16'h7E81, 16'h1357, 1'b1);
      step();
`endif

      // Random traffic with idle gaps, backpressure and rare aborts
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(99) < 60, 4'($urandom), $urandom_range(99) < 70,
               $urandom_range(199) < 3, $urandom_range(999) < 3);
`ifdef PARITY_CHECK_EN
         if ($urandom_range(99) < 3) bus.nibble_par = ~bus.nibble_par;
`endif
         step();
      end
      drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      repeat (3) step();
      check("sb_drained", 64'(sb_q.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bitwise_operand_loader.md
# bitwise_operand_loader

Upstream operand-staging stage for the 16-lane bitwise AND array. It accepts two operands as a stream of 4-bit nibbles, assembles operand A and then operand B, and presents both as stable parallel words with a valid/ready handshake. The `a_out`/`b_out` buses connect directly to the AND array's `a`/`b` inputs. The downstream consumer samples the AND result while `op_valid` is high.

## Interface
- `WIDTH`, default 16: operand width in bits; must be a multiple of 4. `BEATS = WIDTH/4` nibbles per operand.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `clear`  input  1  synchronous abort of the current transaction.
- `nibble_in`  input  4  operand data, least-significant nibble first.
- `nibble_valid`  input  1  `nibble_in` is valid this cycle.
- `nibble_par`  input  1  even-parity bit for `nibble_in`; present only with `PARITY_CHECK_EN`.
- `in_ready`  output  1  the block accepts a nibble this cycle.
- `a_out`  output  WIDTH  assembled operand A.
- `b_out`  output  WIDTH  assembled operand B.
- `op_valid`  output  1  `a_out`/`b_out` hold a complete operand pair.
- `op_ready`  input  1  downstream consumes the pair.
- `load_count`  output  $clog2(2*BEATS)+1  nibbles accepted in the current transaction.
- `parity_err`  output  1  one-cycle pulse when a nibble is rejected for bad parity.

## Operation
- **Accept rule:** a nibble is accepted on an edge where `nibble_valid && in_ready && !clear && !reset`.
- **Internal shift register:** accepted nibbles are shifted in from the MSB end (`sr <= {nibble_in, sr[WIDTH-1:4]}`), so after `BEATS` accepts the first nibble sits in `sr[3:0]`.
- **FSM states:**
  - LOAD_A: count 0..BEATS-1. On accepting nibble BEATS-1, latch `sr` into the A holding register and go to LOAD_B.
  - LOAD_B: count BEATS..2*BEATS-1. On accepting the final nibble, update `a_out` and `b_out` together at the same edge, set `op_valid`, and go to PRESENT.
  - PRESENT: `in_ready` = 0. `a_out`, `b_out` and `op_valid` are held until `op_valid && op_ready`. That edge clears `op_valid`, resets `load_count` to 0 and returns to LOAD_A.
- **`in_ready` decode:** `in_ready` = 1 in LOAD_A and LOAD_B, and 0 in PRESENT. It is decoded from state only and never depends on `nibble_valid`.
- **Output stability:** `a_out` and `b_out` change only at the edge that completes a pair. They keep their last values after a handoff, after `clear`, and until the next pair completes. The AND array therefore never sees a partially loaded operand.
- **`clear`:** from any state, go to LOAD_A with `load_count` = 0 and `op_valid` = 0. Any nibble presented that cycle is dropped. `a_out`/`b_out` are unchanged.
- **Priority:** `reset` > `clear` > parity reject > normal accept.
- `op_ready` is ignored while `op_valid` = 0.
- `nibble_valid` while `in_ready` = 0 is ignored; the source must hold the nibble.

## Timing
- **Reset values:** state LOAD_A, `a_out` = 0, `b_out` = 0, A holding register = 0, `op_valid` = 0, `load_count` = 0, `parity_err` = 0. `in_ready` = 1 while in LOAD_A, including the cycles reset is held.
- **Reset mid-transaction:** all partial state is discarded at the next edge.
- **Minimum load latency:** 2*BEATS accepting edges (8 at WIDTH = 16). `op_valid` is high immediately after the edge that accepts the final nibble.
- **Throughput:** with `op_ready` tied high, PRESENT lasts exactly one cycle. The first nibble of the next pair can be accepted on the following edge, giving one bubble cycle per pair.
- **`load_count` boundary:** holds at 2*BEATS while in PRESENT and wraps to 0 at the handoff edge.

## Configuration
- **`PARITY_CHECK_EN` defined:**
  - The `nibble_par` port exists.
  - A nibble with `^{nibble_in, nibble_par}` = 1 is rejected: the transaction aborts exactly as for `clear`, and `parity_err` pulses high for the cycle after that edge.
  - In PRESENT, `in_ready` = 0, so parity is not checked.
- **`PARITY_CHECK_EN` undefined:** `nibble_par` is absent and `parity_err` is tied to 0.

## Test plan
- **Basic load:** after reset, stream nibbles 0,F,0,F then C,3,C,3 with `op_ready` = 1 → `op_valid` is high for exactly one cycle after the 8th accept, with `a_out` = 16'hF0F0 and `b_out` = 16'h3C3C. The downstream AND output is 16'h3030.
- **Backpressure:** complete a pair with A = 16'h1234 and B = 16'hFFFF, then hold `op_ready` = 0 for 5 cycles → `op_valid` = 1, `in_ready` = 0 and outputs are stable throughout. Raising `op_ready` → `op_valid` = 0 and `in_ready` = 1 on the next edge.
- **Clear:** accept 3 nibbles, then assert `clear` together with `nibble_valid` → `load_count` = 0, the nibble is dropped, and `a_out`/`b_out` keep their previous pair. The next 8 nibbles load a fresh pair.
- **Reset mid-operation:** assert `reset` during LOAD_B at count 6 → all outputs return to their reset values and the next pair loads from count 0.
- **Parity, with `PARITY_CHECK_EN`:** send the 2nd nibble with a wrong parity bit → `parity_err` pulses once, `load_count` = 0 and `op_valid` stays 0. A clean pair loads afterwards.
- **Idle gaps:** deassert `nibble_valid` randomly between nibbles → the result is identical to the gap-free load, and `load_count` increments only on accepts.
